seq_addsub_n: RTL and testbench

//  Multi-cycle N-bit adder/subtractor that reuses one K-bit ripple slice for ceil(N/K) cycles.

---
 rtl/adder_pkg.sv | 15 +
 rtl/addn.sv | 17 +
 rtl/seq_addsub_n.sv | 141 ++++++++++++++
 tb/tb_seq_addsub_n.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and helpers for the sequential adder/subtractor.
//   state_t       : controller states (IDLE accepts work, RUN processes slices)
//   slices(n, k)  : number of k-bit slices needed to cover n bits, ceil(n/k)
package adder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int slices(input int n, input int k);
    return (n + k - 1) / k;
  endfunction

endpackage

// File: rtl/addn.sv
// Combinational generic N-bit adder, used here as the reusable slice.
// Ports:
//   a, b   in  N  addends
//   sum    out N  a + b, low N bits
//   carry  out 1  carry out of bit N-1
module addn #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         carry
);

  assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/seq_addsub_n.sv
// Multi-cycle N-bit adder/subtractor. One K-bit slice adder is reused for
// S = ceil(N/K) cycles; operands shift right by K each cycle while the result
// shifts in from the top.
// Ports:
//   clk, rst   in   1  clock (rising edge), synchronous active-high reset
//   start      in   1  request, taken only while ready=1
//   sub        in   1  0: a+b, 1: a-b (sampled with start)
//   a, b       in   N  operands (sampled with start)
//   ready      out  1  idle, able to accept start
//   done       out  1  one-cycle pulse when sum/carry/overflow update
//   sum        out  N  result
//   carry      out  1  add: carry out; sub: not-borrow (a >= b unsigned)
//   overflow   out  1  two's-complement overflow
module seq_addsub_n
  import adder_pkg::*;
#(
  parameter int N = 16,
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         ready,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         carry,
  output logic         overflow
);

  localparam int S    = slices(N, K);
  localparam int W    = S * K;
  localparam int CW   = $clog2(S + 1);
  // Bit N of the padded result is the true carry when padding exists.
  localparam int CIDX = (N < W) ? N : W - 1;

  state_t        r_state;
  state_t        w_state_next;

  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_res;
  logic          r_c;
  logic [CW-1:0] r_cnt;
  logic          r_sa;
  logic          r_sb;
  logic          r_done;
  logic [N-1:0]  r_sum;
  logic          r_carry;
  logic          r_ovf;

  logic [N-1:0]  w_b_eff;
  logic [K-1:0]  w_add_sum;
  logic          w_add_c;
  logic [K-1:0]  w_cin_sum;
  logic          w_cin_c;
  logic          w_slice_c;
  logic [W-1:0]  w_res_next;
  logic          w_last;
  logic          w_carry_fin;
  logic          w_ovf_fin;

  assign w_b_eff = b ^ {N{sub}};

  addn #(.N(K)) u_slice (
    .a     (r_a[K-1:0]),
    .b     (r_b[K-1:0]),
    .sum   (w_add_sum),
    .carry (w_add_c)
  );

  // Carry-in stage; at most one of the two carries can be set.
  assign {w_cin_c, w_cin_sum} = {1'b0, w_add_sum} + (K+1)'(r_c);
  assign w_slice_c            = w_add_c | w_cin_c;

  assign w_res_next  = (r_res >> K) | (W'(w_cin_sum) << (W - K));
  assign w_last      = (r_cnt == CW'(S - 1));
  assign w_carry_fin = (N < W) ? w_res_next[CIDX] : w_slice_c;
  assign w_ovf_fin   = (r_sa == r_sb) && (w_res_next[N-1] != r_sa);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (r_state == IDLE) begin
      if (start) w_state_next = RUN;
    end else begin
      if (w_last) w_state_next = IDLE;
    end
  end

  always_comb begin
    ready = (r_state == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (start) begin
          r_a   <= W'(a);
          r_b   <= W'(w_b_eff);
          r_c   <= sub;
          r_cnt <= '0;
          r_sa  <= a[N-1];
          r_sb  <= w_b_eff[N-1];
        end
      end else begin
        r_a   <= r_a >> K;
        r_b   <= r_b >> K;
        r_c   <= w_slice_c;
        r_res <= w_res_next;
        r_cnt <= r_cnt + CW'(1);
        if (w_last) begin
          r_cnt   <= '0;
          r_done  <= 1'b1;
          r_sum   <= w_res_next[N-1:0];
          r_carry <= w_carry_fin;
          r_ovf   <= w_ovf_fin;
        end
      end
    end
  end

  assign done     = r_done;
  assign sum      = r_sum;
  assign carry    = r_carry;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_seq_addsub_n.sv
module tb_seq_addsub_n;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sub;
  logic [15:0] a_d;
  logic [15:0] b_d;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Reference: {overflow, carry, sum[15:0]} of an n-bit add or subtract.
  function automatic logic [17:0] ref_op(input int n, input logic s,
                                         input logic [15:0] x, input logic [15:0] y);
    longint mask, ua, ub, sa, sb, r, full, lim;
    logic   c, ov;
    logic [15:0] sm;
    mask = (longint'(1) << n) - 1;
    lim  = longint'(1) << (n - 1);
    ua   = longint'(x) & mask;
    ub   = longint'(y) & mask;
    sa   = (ua >= lim) ? ua - (longint'(1) << n) : ua;
    sb   = (ub >= lim) ? ub - (longint'(1) << n) : ub;
    if (!s) begin
      full = ua + ub;
      c    = ((full >> n) != 0);
      r    = sa + sb;
    end else begin
      full = ua - ub;
      c    = (ua >= ub);
      r    = sa - sb;
    end
    sm = 16'(full & mask);
    ov = (r < -lim) || (r > lim - 1);
    return {ov, c, sm};
  endfunction

  task automatic chk(input string nm, input int id,
                     input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d got=%h want=%h t=%0t", nm, id, got, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 5; gi++) begin : g_inst
    localparam int NN = (gi == 0) ? 16 : (gi == 1) ? 5 : (gi == 2) ? 7 : (gi == 3) ? 3 : 1;
    localparam int KK = (gi == 0) ? 4  : (gi == 1) ? 3 : (gi == 2) ? 7 : 1;
    localparam int SS = (NN + KK - 1) / KK;

    logic          w_ready;
    logic          w_done;
    logic          w_carry;
    logic          w_ovf;
    logic [NN-1:0] w_sum;

    seq_addsub_n #(.N(NN), .K(KK)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .sub      (sub),
      .a        (a_d[NN-1:0]),
      .b        (b_d[NN-1:0]),
      .ready    (w_ready),
      .done     (w_done),
      .sum      (w_sum),
      .carry    (w_carry),
      .overflow (w_ovf)
    );

    // Model: a busy countdown plus the arithmetic result it will deliver.
    int          m_busy = 0;
    logic        m_done = 1'b0;
    logic        m_live = 1'b0;
    logic [17:0] m_pend = '0;
    logic [17:0] m_out  = '0;

    always @(posedge clk) begin
      if (rst) begin
        m_busy = 0;
        m_done = 1'b0;
        m_out  = '0;
        m_live = 1'b1;
      end else if (m_busy == 0) begin
        m_done = 1'b0;
        if (start) begin
          m_pend = ref_op(NN, sub, a_d, b_d);
          m_busy = SS;
        end
      end else begin
        m_busy = m_busy - 1;
        m_done = (m_busy == 0);
        if (m_done) m_out = m_pend;
      end
    end

    always @(negedge clk) begin
      if (m_live) begin
        chk("ready", gi, 32'(w_ready), 32'(m_busy == 0));
        chk("done",  gi, 32'(w_done),  32'(m_done));
        chk("sum",   gi, 32'(w_sum),   32'(m_out[15:0]));
        chk("carry", gi, 32'(w_carry), 32'(m_out[16]));
        chk("ovf",   gi, 32'(w_ovf),   32'(m_out[17]));
      end
    end
  end

  task automatic op(input logic s, input logic [15:0] x, input logic [15:0] y);
    start = 1'b1;
    sub   = s;
    a_d   = x;
    b_d   = y;
    @(posedge clk); #1;
    start = 1'b0;
    sub   = 1'($urandom);
    a_d   = 16'($urandom);
    b_d   = 16'($urandom);
    repeat (6) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] main_out();
    return 32'({g_inst[0].w_ovf, g_inst[0].w_carry, g_inst[0].w_sum});
  endfunction

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a_d   = '0;
    b_d   = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Hand-computed pins on the model itself.
    chk("pin_ffff_add", 99, 32'(ref_op(16, 1'b0, 16'hFFFF, 16'h0001)), 32'h10000);
    chk("pin_7fff_add", 99, 32'(ref_op(16, 1'b0, 16'h7FFF, 16'h0001)), 32'h28000);
    chk("pin_5m7_sub",  99, 32'(ref_op(16, 1'b1, 16'h0005, 16'h0007)), 32'h0FFFE);
    chk("pin_8000_sub", 99, 32'(ref_op(16, 1'b1, 16'h8000, 16'h0001)), 32'h37FFF);
    chk("pin_eq_sub",   99, 32'(ref_op(16, 1'b1, 16'h1234, 16'h1234)), 32'h10000);
    chk("pin_n5_add",   99, 32'(ref_op(5,  1'b0, 16'h0010, 16'h0010)), 32'h30000);

    op(1'b0, 16'hFFFF, 16'h0001);
    chk("dut_ffff_add", 0, main_out(), 32'h10000);
    op(1'b0, 16'h7FFF, 16'h0001);
    chk("dut_7fff_add", 0, main_out(), 32'h28000);
    op(1'b1, 16'h0005, 16'h0007);
    chk("dut_5m7_sub", 0, main_out(), 32'h0FFFE);
    op(1'b1, 16'h8000, 16'h0001);
    chk("dut_8000_sub", 0, main_out(), 32'h37FFF);
    op(1'b1, 16'h1234, 16'h1234);
    chk("dut_eq_sub", 0, main_out(), 32'h10000);

    // Second start two cycles into an operation.
    start = 1'b1; sub = 1'b0; a_d = 16'h0100; b_d = 16'h0023;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 start = 1'b1; a_d = 16'hAAAA; b_d = 16'h5555;
    @(posedge clk); #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #1 chk("dut_ignored_start", 0, main_out(), 32'h00123);

    // Start held high: every idle cycle takes a new request.
    start = 1'b1;
    for (int i = 0; i < 14; i++) begin
      sub = 1'($urandom); a_d = 16'($urandom); b_d = 16'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // Reset two cycles into RUN.
    start = 1'b1; sub = 1'b0; a_d = 16'h1111; b_d = 16'h2222;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("dut_after_rst", 0, main_out(), 32'h0);
    op(1'b0, 16'h1111, 16'h2222);
    chk("dut_post_rst_op", 0, main_out(), 32'h03333);

    op(1'b0, 16'h0000, 16'h0000);
    op(1'b1, 16'h0000, 16'h0000);
    op(1'b0, 16'hFFFF, 16'hFFFF);
    op(1'b1, 16'hFFFF, 16'hFFFF);
    op(1'b1, 16'h0000, 16'h8000);

    for (int i = 0; i < 600; i++) begin
      start = 1'($urandom);
      sub   = 1'($urandom);
      a_d   = 16'($urandom);
      b_d   = 16'($urandom);
      rst   = ($urandom_range(0, 63) == 0);
      @(posedge clk); #1;
    end
    rst   = 1'b0;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
